// File: rtl/microsequencer_pkg.sv
// rtl/microsequencer_pkg.sv - shared widths, sequencing op and condition encodings
package microsequencer_pkg;

  localparam int STATE_W          = 7;
  localparam int DEF_NUM_STATES   = 13;
  localparam int DEF_FETCH_STATE  = 1;
  localparam int DEF_WAIT_TIMEOUT = 15;

  localparam logic [STATE_W-1:0] RESET_STATE = '0;

  typedef enum logic [2:0] {
    NS_DISPATCH = 3'b000,
    NS_FETCH    = 3'b001,
    NS_INC      = 3'b010,
    NS_JUMP     = 3'b011,
    NS_BR_T     = 3'b100,
    NS_BR_F     = 3'b101,
    NS_WAIT     = 3'b110,
    NS_RSVD     = 3'b111
  } ns_op_e;

  typedef enum logic [2:0] {
    COND_Z     = 3'd0,
    COND_N     = 3'd1,
    COND_C     = 3'd2,
    COND_V     = 3'd3,
    COND_MOC   = 3'd4,
    COND_TRUE  = 3'd5,
    COND_FALSE = 3'd6,
    COND_NONE  = 3'd7
  } cond_sel_e;

  // Wraps at 2**STATE_W; the caller range-checks the result.
  function automatic logic [STATE_W-1:0] state_inc(input logic [STATE_W-1:0] s);
    return s + STATE_W'(1);
  endfunction

endpackage

// File: rtl/microsequencer_if.sv
// rtl/microsequencer_if.sv - control-word, flag and state signals between control unit and sequencer
interface microsequencer_if;
  import microsequencer_pkg::*;

  logic [2:0]         ns_sel;
  logic [2:0]         cond_sel;
  logic [STATE_W-1:0] cr;
  logic [STATE_W-1:0] dispatch_state;
  logic               stall;
  logic               flag_z;
  logic               flag_n;
  logic               flag_c;
  logic               flag_v;
  logic               mem_ready;
  logic [STATE_W-1:0] current_state;
  logic               seq_error;

  modport master (
    output ns_sel, cond_sel, cr, dispatch_state, stall,
    output flag_z, flag_n, flag_c, flag_v, mem_ready,
    input  current_state, seq_error
  );

  modport slave (
    input  ns_sel, cond_sel, cr, dispatch_state, stall,
    input  flag_z, flag_n, flag_c, flag_v, mem_ready,
    output current_state, seq_error
  );

endinterface

// File: rtl/microsequencer_cond_select.sv
// rtl/microsequencer_cond_select.sv - 8:1 branch condition mux over ALU flags and memory ready
module cond_select
  import microsequencer_pkg::*;
(
  input  logic [2:0] cond_sel,
  input  logic       flag_z,
  input  logic       flag_n,
  input  logic       flag_c,
  input  logic       flag_v,
  input  logic       mem_ready,
  output logic       cond
);

  always_comb begin
    cond = 1'b0;
    case (cond_sel_e'(cond_sel))
      COND_Z:    cond = flag_z;
      COND_N:    cond = flag_n;
      COND_C:    cond = flag_c;
      COND_V:    cond = flag_v;
      COND_MOC:  cond = mem_ready;
      COND_TRUE: cond = 1'b1;
      default:   cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/microsequencer.sv
// rtl/microsequencer.sv - control-state register and next-state engine feeding the microstore
module microsequencer
  import microsequencer_pkg::*;
#(
  parameter int NUM_STATES   = DEF_NUM_STATES,
  parameter int FETCH_STATE  = DEF_FETCH_STATE,
  parameter int WAIT_TIMEOUT = DEF_WAIT_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset_n,
  microsequencer_if.slave  bus
);

  localparam int                 CNT_W      = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(WAIT_TIMEOUT);
  localparam logic [STATE_W-1:0] LAST_STATE = STATE_W'(NUM_STATES - 1);
  localparam logic [STATE_W-1:0] FETCH_TGT  = STATE_W'(FETCH_STATE);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [STATE_W-1:0] target;
  logic [STATE_W-1:0] inc;
  logic               force_err;
  logic               cond;

  cond_select u_cond_select (
    .cond_sel  (bus.cond_sel),
    .flag_z    (bus.flag_z),
    .flag_n    (bus.flag_n),
    .flag_c    (bus.flag_c),
    .flag_v    (bus.flag_v),
    .mem_ready (bus.mem_ready),
    .cond      (cond)
  );

  assign inc = state_inc(state_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    target    = state_q;
    force_err = 1'b0;
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    if (!bus.stall) begin
      // Any cycle that does not hold in WAIT restarts the timeout count.
      cnt_d = '0;
      case (ns_op_e'(bus.ns_sel))
        NS_DISPATCH: target = bus.dispatch_state;
        NS_FETCH:    target = FETCH_TGT;
        NS_INC:      target = inc;
        NS_JUMP:     target = bus.cr;
        NS_BR_T:     target = cond ? bus.cr : inc;
        NS_BR_F:     target = cond ? inc : bus.cr;
        NS_WAIT: begin
          if (bus.mem_ready) begin
            target = inc;
          end else if (cnt_q == CNT_MAX) begin
            force_err = 1'b1;
          end else begin
            target = state_q;
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end
        default:     force_err = 1'b1;
      endcase
      if (force_err || target > LAST_STATE) begin
        state_d = RESET_STATE;
        err_d   = 1'b1;
      end else begin
        state_d = target;
      end
    end
  end

  assign bus.current_state = state_q;
  assign bus.seq_error     = err_q;

endmodule
